alu_exec: RTL and testbench
===========================

# alu_exec

Sequential execute-stage ALU that consumes the 4-bit `ALUCtrl` code produced by the ALU control decoder. It computes the result of one operation per accepted request. It accepts operands through a valid/ready handshake and returns a registered result with `Zero` and `Overflow` flags through a one-entry output register. Shifts run iteratively, one bit per cycle, unless the fast shifter is compiled in.

## Interface
- `WIDTH`, 32, datapath width.
- `SHW`, 5, shift-amount width; equals log2(`WIDTH`).
- `CLK` input 1: sole clock; all state updates on its rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `InValid` input 1: request valid.
- `InReady` output 1: block accepts a request this cycle.
- `ALUCtrl` input 4: operation code.
- `BusA` input WIDTH: operand A.
- `BusB` input WIDTH: operand B; this is the shifted operand for shifts.
- `Shamt` input SHW: shift amount.
- `OutValid` output 1: result valid.
- `OutReady` input 1: consumer takes the result.
- `BusW` output WIDTH: result.
- `Zero` output 1: `BusW == 0`.
- `Overflow` output 1: signed overflow on ADD or SUB.

## Operation
- `ALUCtrl` encoding:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0011 SLL.
  - 0100 SRL.
  - 0101 SRA.
  - 0110 SUB.
  - 0111 SLT (signed).
  - 1000 ADDU.
  - 1001 SUBU.
  - 1010 XOR.
  - 1011 SLTU.
  - 1100 NOR.
  - 1101 LUI: `BusB << 16`.
  - 1110 and 1111: result 0, no flags.
- Arithmetic is modulo 2^WIDTH.
  - SLT and SLTU write 1 or 0, zero-extended.
  - `Overflow` is set only for ADD and SUB, when operand signs make the result sign impossible.
  - `BusW` is still written on overflow.
  - `Overflow` is never set for ADDU or SUBU.
- Shifts operate on `BusB` by `Shamt`. SRA replicates `BusB[WIDTH-1]`.
- Operands and code are captured at acceptance; later input changes have no effect.
- Accept condition: `InValid && InReady`.
- FSM states:
  - IDLE: `InReady`=1, `OutValid`=0.
    - On accept of a non-shift op, or a shift with `Shamt`=0: compute, load the output register, go to DONE.
    - On accept of a shift with `Shamt`≠0: load the shift register with `BusB`, load the counter with `Shamt`, go to SHIFT.
  - SHIFT: `InReady`=0, `OutValid`=0.
    - Shift one bit per cycle and decrement the counter.
    - When the counter reaches 1, the final shift step loads the output register and the state goes to DONE.
  - DONE: `OutValid`=1. `InReady` equals `OutReady`.
    - `OutReady`=1 with no new accept: go to IDLE.
    - `OutReady`=1 with a simultaneous accept: treat exactly as an accept in IDLE; this is the back-to-back path.
    - `OutReady`=0: hold `BusW`, `Zero`, `Overflow` stable.
- `Zero` and `Overflow` are registered together with `BusW`.

## Timing
- Reset values:
  - State IDLE.
  - `OutValid`=0.
  - `BusW`=0.
  - `Zero`=0.
  - `Overflow`=0.
  - Shift counter 0.
  - `InReady` is 1 after the reset cycle.
- Reset asserted in any state aborts the operation in that cycle; no result is delivered.
- Latency, measured from the accept edge to `OutValid` high:
  - Non-shift ops, and shifts with `Shamt`=0: 1 cycle.
  - Iterative shift by k: k+1 cycles (k cycles in SHIFT), maximum `WIDTH`.
- Throughput for non-shift ops with `OutReady` held high: one result per cycle.
- `OutValid` never drops without `OutReady`=1, and outputs are stable while `OutValid` && !`OutReady`.
- `InReady` is combinational from state and `OutReady`. No other path from input to output is combinational.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - Shifts use a single-cycle barrel shifter and follow the non-shift path: latency 1, SHIFT state unused.
  - The shift register and counter are not built.
- `ALU_FAST_SHIFT_EN` undefined:
  - Iterative shifter as specified above.
  - Functional results are identical in both builds; only latency differs.

## Test plan
- Reset mid-SHIFT:
  - Stimulus: SLL `BusB`=1, `Shamt`=20; assert `Reset` 3 cycles after accept.
  - Required response: `OutValid` stays 0, `BusW`=0, `InReady`=1 the next cycle.
  - Then issue ADD 5+7 → `BusW`=12 one cycle after accept.
- Overflow:
  - ADD 0x7FFFFFFF+1 → `BusW`=0x80000000, `Overflow`=1.
  - ADDU with the same operands → `Overflow`=0.
  - SUB 0x80000000−1 → `Overflow`=1.
- Flags and compares:
  - SUB 9−9 → `BusW`=0, `Zero`=1.
  - SLT 0xFFFFFFFF,1 → 1.
  - SLTU 0xFFFFFFFF,1 → 0.
  - NOR 0,0 → 0xFFFFFFFF.
- Iterative shifts (macro undefined):
  - SRA `BusB`=0x80000000, `Shamt`=4 → 0xF8000000 with `OutValid` 5 cycles after accept.
  - SRL with the same inputs → 0x08000000.
  - `Shamt`=0 → latency 1.
  - With `ALU_FAST_SHIFT_EN` defined, all shift latencies are 1.
- Backpressure:
  - Hold `OutReady`=0 for 4 cycles after an AND result 0x0F0F0F0F&0x00FF00FF=0x000F000F.
  - Required response: `BusW` stable, `InReady`=0.
  - Then drive `OutReady`=1 together with a new OR request → next cycle `BusW`=the new OR result.
- Streaming:
  - 8 back-to-back ADDs with `OutReady`=1 → 8 consecutive `OutValid` cycles with results in order.
  - Unused codes 1110 and 1111 → `BusW`=0, `Zero`=1, `Overflow`=0.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with a valid/ready request port and a one-entry result register.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; the default build shifts one bit per cycle.
module alu_exec #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [3:0]       ALUCtrl,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [SHW-1:0]   Shamt,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] BusW,
   output logic             Zero,
   output logic             Overflow
);

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SLL  = 4'b0011,
      OP_SRL  = 4'b0100,
      OP_SRA  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_ADDU = 4'b1000,
      OP_SUBU = 4'b1001,
      OP_XOR  = 4'b1010,
      OP_SLTU = 4'b1011,
      OP_NOR  = 4'b1100,
      OP_LUI  = 4'b1101,
      OP_RSV0 = 4'b1110,
      OP_RSV1 = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] busw_q, busw_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic [WIDTH-1:0] res_c;
   logic             ovf_c;
   logic             start_shift;
   logic             shift_last;
   logic [WIDTH-1:0] shift_res;

   // Single-cycle result for every code; shifts here only cover the shift-by-zero case.
   function automatic logic [WIDTH:0] alu_compute(input alu_op_e          op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] diff;
      logic [WIDTH-1:0] res;
      logic             ovf;
      sum  = a + b;
      diff = a - b;
      res  = '0;
      ovf  = 1'b0;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD: begin
            res = sum;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res = diff;
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_ADDU: res = sum;
         OP_SUBU: res = diff;
         OP_XOR:  res = a ^ b;
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_NOR:  res = ~(a | b);
         OP_LUI:  res = b << 16;
         OP_SLL, OP_SRL, OP_SRA: res = b;
         default: res = '0;
      endcase
      return {ovf, res};
   endfunction

   assign InReady = (state_q == S_IDLE) || ((state_q == S_DONE) && OutReady);
   assign accept  = InValid && InReady;

   always_comb begin
      {ovf_c, res_c} = alu_compute(alu_op_e'(ALUCtrl), BusA, BusB);
`ifdef ALU_FAST_SHIFT_EN
      case (alu_op_e'(ALUCtrl))
         OP_SLL:  res_c = BusB << Shamt;
         OP_SRL:  res_c = BusB >> Shamt;
         OP_SRA:  res_c = $signed(BusB) >>> Shamt;
         default: ;
      endcase
`endif
   end

`ifndef ALU_FAST_SHIFT_EN
   logic [WIDTH-1:0] sh_q;
   logic [SHW-1:0]   cnt_q;
   alu_op_e          kind_q;
   logic [WIDTH-1:0] sh_step;

   assign start_shift = accept && (Shamt != '0) &&
                        (alu_op_e'(ALUCtrl) inside {OP_SLL, OP_SRL, OP_SRA});
   assign shift_last  = (state_q == S_SHIFT) && (cnt_q == SHW'(1));

   always_comb begin
      case (kind_q)
         OP_SLL:  sh_step = sh_q << 1;
         OP_SRA:  sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
         default: sh_step = sh_q >> 1;
      endcase
   end

   assign shift_res = sh_step;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         cnt_q  <= '0;
         kind_q <= OP_SLL;
      end else if (start_shift) begin
         cnt_q  <= Shamt;
         kind_q <= alu_op_e'(ALUCtrl);
      end else if (state_q == S_SHIFT) begin
         cnt_q  <= cnt_q - SHW'(1);
      end
   end

   // NOTE: the shift datapath register carries no reset; it is always loaded before it is read.
   always_ff @(posedge CLK) begin
      if (start_shift) begin
         sh_q <= BusB;
      end else if (state_q == S_SHIFT) begin
         sh_q <= sh_step;
      end
   end
`else
   assign start_shift = 1'b0;
   assign shift_last  = 1'b0;
   assign shift_res   = '0;
`endif

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      busw_d  = busw_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if ((state_q == S_DONE) && OutReady) begin
               state_d = S_IDLE;
            end
            if (start_shift) begin
               state_d = S_SHIFT;
            end else if (accept) begin
               busw_d  = res_c;
               zero_d  = (res_c == '0);
               ovf_d   = ovf_c;
               state_d = S_DONE;
            end
         end
         S_SHIFT: begin
            if (shift_last) begin
               busw_d  = shift_res;
               zero_d  = (shift_res == '0);
               ovf_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_IDLE;
         busw_q  <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busw_q  <= busw_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign OutValid = (state_q == S_DONE);
   assign BusW     = busw_q;
   assign Zero     = zero_q;
   assign Overflow = ovf_q;

   // A stalled result must hold until the consumer takes it.
   assert property (@(posedge CLK) disable iff (Reset)
      (OutValid && !OutReady) |=> (OutValid && $stable(BusW) && $stable(Zero) && $stable(Overflow)));

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against a cycle-aware behavioural model.
module tb_alu_exec;

`ifdef ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam longint S_MAX = 64'sd2147483647;
   localparam longint S_MIN = -64'sd2147483648;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [3:0]  ALUCtrl;
   logic [31:0] BusA;
   logic [31:0] BusB;
   logic [4:0]  Shamt;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] BusW;
   logic        Zero;
   logic        Overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;
   bit mon_en  = 1'b0;
   bit rand_ready = 1'b0;

   // Model state: at most one outstanding result, visible from edge 'due' on.
   bit          have_item = 1'b0;
   logic [33:0] item = '0;
   int          due = 0;
   bit          mv;
   bit          mr;

   alu_exec #(.WIDTH(32), .SHW(5)) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .InValid  (InValid),
      .InReady  (InReady),
      .ALUCtrl  (ALUCtrl),
      .BusA     (BusA),
      .BusB     (BusB),
      .Shamt    (Shamt),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .BusW     (BusW),
      .Zero     (Zero),
      .Overflow (Overflow)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_n++;

   always @(posedge CLK) begin
      #1;
      if (rand_ready) OutReady = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Returns {overflow, zero, result} from the instruction-set definition.
   function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
      longint      sa;
      longint      sb;
      longint      full;
      logic [31:0] r;
      logic        o;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      o  = 1'b0;
      case (op)
         4'h0: r = a & b;
         4'h1: r = a | b;
         4'h2: begin full = sa + sb; r = full[31:0]; o = (full > S_MAX) || (full < S_MIN); end
         4'h3: r = b << sh;
         4'h4: r = b >> sh;
         4'h5: r = 32'($signed(b) >>> sh);
         4'h6: begin full = sa - sb; r = full[31:0]; o = (full > S_MAX) || (full < S_MIN); end
         4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
         4'h8: r = a + b;
         4'h9: r = a - b;
         4'hA: r = a ^ b;
         4'hB: r = (a < b) ? 32'd1 : 32'd0;
         4'hC: r = ~(a | b);
         4'hD: r = b << 16;
         default: r = '0;
      endcase
      return {o, (r == '0), r};
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [4:0] sh);
      int lat;
      lat = 1;
      if (!FAST && (op >= 4'h3) && (op <= 4'h5) && (sh != '0)) lat = int'(sh) + 1;
      return lat;
   endfunction

   // Compare process: outputs checked every cycle, then the next edge is predicted.
   always @(negedge CLK) begin
      if (mon_en) begin
         mv = have_item && (edge_n >= due);
         mr = !have_item || (mv && OutReady);
         check("mon_outvalid", 64'(OutValid), 64'(mv));
         check("mon_inready", 64'(InReady), 64'(mr));
         if (mv) begin
            check("mon_busw", 64'(BusW), 64'(item[31:0]));
            check("mon_zero", 64'(Zero), 64'(item[32]));
            check("mon_overflow", 64'(Overflow), 64'(item[33]));
         end
         if (Reset) begin
            have_item = 1'b0;
         end else begin
            if (mv && OutReady) have_item = 1'b0;
            if (InValid && mr) begin
               item      = ref_alu(ALUCtrl, BusA, BusB, Shamt);
               due       = edge_n + ref_lat(ALUCtrl, Shamt);
               have_item = 1'b1;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int acc_edge);
      bit rdy;
      int guard;
      ALUCtrl = op; BusA = a; BusB = b; Shamt = sh; InValid = 1'b1;
      guard = 0;
      forever begin
         @(negedge CLK);
         rdy = InReady;
         @(posedge CLK);
         #1;
         if (rdy) break;
         guard++;
         if (guard >= 200) begin
            check("issue_inready_timeout", 64'(InReady), 64'(1));
            break;
         end
      end
      acc_edge = edge_n;
      InValid = 1'b0;
      ALUCtrl = 4'($urandom_range(0, 15));
      BusA = $urandom; BusB = $urandom;
      Shamt = 5'($urandom_range(0, 31));
   endtask

   // Returns at the first negedge showing OutValid.
   task automatic wait_result(input int acc_edge, output int lat, output bit ok);
      ok = 1'b0;
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (OutValid) begin
            ok = 1'b1;
            lat = edge_n - acc_edge + 1;
            break;
         end
      end
      if (!ok) check("wait_outvalid_timeout", 64'(OutValid), 64'(1));
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_r,
                         input logic exp_z, input logic exp_o, input int exp_lat);
      int acc;
      int lat;
      bit ok;
      issue(op, a, b, sh, acc);
      wait_result(acc, lat, ok);
      if (ok) begin
         check({name, "_busw"}, 64'(BusW), 64'(exp_r));
         check({name, "_zero"}, 64'(Zero), 64'(exp_z));
         check({name, "_ovf"}, 64'(Overflow), 64'(exp_o));
         check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      end
      @(posedge CLK);
      #1;
   endtask

   logic [31:0] s_exp [8];
   logic [31:0] ra;
   logic [31:0] rb;
   logic [3:0]  rop;
   logic [4:0]  rsh;
   int          acc_e;
   int          e0;
   int          lat_v;
   bit          ok_v;

   initial begin
      Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
      ALUCtrl = '0; BusA = '0; BusB = '0; Shamt = '0;
      repeat (2) @(posedge CLK);
      #1;
      Reset = 1'b0;
      mon_en = 1'b1;
      @(negedge CLK);
      check("rst_outvalid", 64'(OutValid), 64'(0));
      check("rst_inready", 64'(InReady), 64'(1));
      check("rst_busw", 64'(BusW), 64'(0));
      check("rst_zero", 64'(Zero), 64'(0));
      check("rst_ovf", 64'(Overflow), 64'(0));
      @(posedge CLK);
      #1;

      // Hand-computed values pin the model.
      check("pin_add_ovf", 64'(ref_alu(4'h2, 32'h7FFF_FFFF, 32'h1, 5'd0)), 64'({1'b1, 1'b0, 32'h8000_0000}));
      check("pin_sra", 64'(ref_alu(4'h5, 32'h0, 32'h8000_0000, 5'd4)), 64'({1'b0, 1'b0, 32'hF800_0000}));
      check("pin_slt", 64'(ref_alu(4'h7, 32'hFFFF_FFFF, 32'h1, 5'd0)), 64'({1'b0, 1'b0, 32'h1}));
      check("pin_sub_zero", 64'(ref_alu(4'h6, 32'd9, 32'd9, 5'd0)), 64'({1'b0, 1'b1, 32'h0}));

      run_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1);
      run_op("addu_noovf", 4'h8, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1);
      run_op("sub_ovf", 4'h6, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
      run_op("subu_noovf", 4'h9, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1);
      run_op("sub_zero", 4'h6, 32'd9, 32'd9, 5'd0, 32'h0, 1'b1, 1'b0, 1);
      run_op("slt", 4'h7, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1);
      run_op("sltu", 4'hB, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1);
      run_op("nor", 4'hC, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      run_op("xor", 4'hA, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'hF0F0_F0F0, 1'b0, 1'b0, 1);
      run_op("lui", 4'hD, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 1'b0, 1);
      run_op("sra4", 4'h5, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, FAST ? 1 : 5);
      run_op("srl4", 4'h4, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, FAST ? 1 : 5);
      run_op("sll0", 4'h3, 32'h0, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 1);
      run_op("sll31", 4'h3, 32'h0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 1'b0, FAST ? 1 : 32);
      run_op("srl_out", 4'h4, 32'h0, 32'h0000_0001, 5'd1, 32'h0, 1'b1, 1'b0, FAST ? 1 : 2);
      run_op("rsv_e", 4'hE, $urandom, $urandom, 5'd0, 32'h0, 1'b1, 1'b0, 1);
      run_op("rsv_f", 4'hF, $urandom, $urandom, 5'd0, 32'h0, 1'b1, 1'b0, 1);

      // Reset three edges after a long shift is accepted.
      issue(4'h3, 32'h0, 32'h1, 5'd20, acc_e);
      repeat (2) begin @(posedge CLK); #1; end
      Reset = 1'b1;
      @(posedge CLK);
      #1;
      Reset = 1'b0;
      @(negedge CLK);
      check("rstshift_outvalid", 64'(OutValid), 64'(0));
      check("rstshift_busw", 64'(BusW), 64'(0));
      check("rstshift_inready", 64'(InReady), 64'(1));
      @(posedge CLK);
      #1;
      run_op("add_after_rst", 4'h2, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0, 1);

      // Backpressure, then release together with a new request.
      OutReady = 1'b0;
      issue(4'h0, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd0, acc_e);
      wait_result(acc_e, lat_v, ok_v);
      check("bp_and_busw", 64'(BusW), 64'(32'h000F_000F));
      repeat (4) begin
         @(posedge CLK);
         #1;
         @(negedge CLK);
         check("bp_hold_busw", 64'(BusW), 64'(32'h000F_000F));
         check("bp_hold_inready", 64'(InReady), 64'(0));
         check("bp_hold_outvalid", 64'(OutValid), 64'(1));
      end
      @(posedge CLK);
      #1;
      OutReady = 1'b1;
      e0 = edge_n;
      issue(4'h1, 32'h1234_0000, 32'h0000_5678, 5'd0, acc_e);
      check("bp_accept_edge", 64'(acc_e), 64'(e0 + 1));
      @(negedge CLK);
      check("bp_or_busw", 64'(BusW), 64'(32'h1234_5678));
      check("bp_or_outvalid", 64'(OutValid), 64'(1));
      @(posedge CLK);
      #1;

      // Eight back-to-back ADDs.
      for (int i = 0; i < 8; i++) begin
         ra = $urandom; rb = $urandom;
         s_exp[i] = ra + rb;
         ALUCtrl = 4'h2; BusA = ra; BusB = rb; Shamt = '0; InValid = 1'b1;
         @(negedge CLK);
         if (i > 0) begin
            check("stream_outvalid", 64'(OutValid), 64'(1));
            check("stream_busw", 64'(BusW), 64'(s_exp[i-1]));
         end
         check("stream_inready", 64'(InReady), 64'(1));
         @(posedge CLK);
         #1;
      end
      InValid = 1'b0;
      @(negedge CLK);
      check("stream_last_outvalid", 64'(OutValid), 64'(1));
      check("stream_last_busw", 64'(BusW), 64'(s_exp[7]));
      @(posedge CLK);
      #1;

      // Randomized traffic with random consumer stalls.
      rand_ready = 1'b1;
      for (int t = 0; t < 300; t++) begin
         rop = 4'($urandom_range(0, 15));
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h7FFF_FFFF;
            1: rb = 32'h8000_0000;
            2: rb = ra;
            default: ;
         endcase
         rsh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
         e0 = n_fail;
         issue(rop, ra, rb, rsh, acc_e);
         repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
         if (n_fail > e0 + 20) break;
      end
      rand_ready = 1'b0;
      @(posedge CLK);
      #2;
      OutReady = 1'b1;
      repeat (40) @(posedge CLK);
      #1;
      @(negedge CLK);
      check("drain_outvalid", 64'(OutValid), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
